timer_bus_arbiter: RTL and testbench

Round-robin arbiter that shares the timer's single register port (6-bit address, 8-bit write data, write enable, 8-bit read data) between NUM_REQ independent requesters, such as the CPU bridge and a DMA/config loader. It sits between the requesters and the `d_ip_timer` register interface. It serialises accesses and returns read data and write completions per requester. It also supports a bus lock so one requester can do an atomic read-modify-write sequence.

---
 rtl/timer_bus_arbiter_if.sv | 31 +++
 rtl/timer_bus_arbiter.sv | 124 ++++++++++++
 tb/tb_timer_bus_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/timer_bus_arbiter_if.sv
// Requester and timer-register bus shared by timer_bus_arbiter.
// The slave modport is the arbiter's view; master is the requesters plus timer.
interface timer_bus_arbiter_if #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ADDR_W  = 6,
  parameter int unsigned DATA_W  = 8
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        req_wr;
  logic [NUM_REQ-1:0]        req_lock;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_rdata;
  logic                      busy;
  logic [ADDR_W-1:0]         t_addr;
  logic                      t_wr_en;
  logic [DATA_W-1:0]         t_wdata;
  logic [DATA_W-1:0]         t_rdata;

  modport slave (
    input  req, req_wr, req_lock, req_addr, req_wdata, t_rdata,
    output gnt, rsp_valid, rsp_rdata, busy, t_addr, t_wr_en, t_wdata
  );

  modport master (
    output req, req_wr, req_lock, req_addr, req_wdata, t_rdata,
    input  gnt, rsp_valid, rsp_rdata, busy, t_addr, t_wr_en, t_wdata
  );
endinterface

// File: rtl/timer_bus_arbiter.sv
// Round-robin arbiter serialising NUM_REQ requesters onto the timer register port,
// one access per three cycles, with an optional bus lock for read-modify-write.
module timer_bus_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ADDR_W  = 6,
  parameter int unsigned DATA_W  = 8
) (
  input logic                clk_i,
  input logic                rst_ni,
  timer_bus_arbiter_if.slave bus
);
  localparam int unsigned IdW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e             state_q, state_d;
  logic [IdW-1:0]     ptr_q, ptr_d;
  logic [IdW-1:0]     win_q, win_d;
  logic [IdW-1:0]     owner_q, owner_d;
  logic               lock_q, lock_d;
  logic               lock_req_q, lock_req_d;
  logic               wr_q, wr_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;

  logic               lock_live;
  logic [NUM_REQ-1:0] elig;
  logic               found;
  logic [IdW-1:0]     pick;
  logic [IdW-1:0]     cand;

  // A lock whose owner has dropped req no longer restricts eligibility.
  always_comb begin
    lock_live = lock_q && bus.req[owner_q];
    elig      = lock_live ? (bus.req & (NUM_REQ'(1) << owner_q)) : bus.req;
    found     = 1'b0;
    pick      = '0;
    cand      = '0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      cand = IdW'((32'(ptr_q) + off) % NUM_REQ);
      if (!found && elig[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    win_d      = win_q;
    owner_d    = owner_q;
    lock_d     = lock_q;
    lock_req_d = lock_req_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (lock_q && !bus.req[owner_q]) lock_d = 1'b0;
        if (found) begin
          state_d    = StAccess;
          win_d      = pick;
          ptr_d      = pick;
          wr_d       = bus.req_wr[pick];
          lock_req_d = bus.req_lock[pick];
          addr_d     = bus.req_addr[32'(pick)*ADDR_W +: ADDR_W];
          wdata_d    = bus.req_wdata[32'(pick)*DATA_W +: DATA_W];
        end
      end
      StAccess: begin
        rdata_d = wr_q ? '0 : bus.t_rdata;
        if (lock_req_q) begin
          lock_d  = 1'b1;
          owner_d = win_q;
        end else if (lock_q && (owner_q == win_q)) begin
          lock_d = 1'b0;
        end
        state_d = StResp;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      ptr_q      <= IdW'(NUM_REQ - 1);
      win_q      <= '0;
      owner_q    <= '0;
      lock_q     <= 1'b0;
      lock_req_q <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      win_q      <= win_d;
      owner_q    <= owner_d;
      lock_q     <= lock_d;
      lock_req_q <= lock_req_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
    end
  end

  // Timer address/data are the held payload, so they stay put between accesses.
  always_comb begin
    bus.gnt       = (state_q == StAccess) ? (NUM_REQ'(1) << win_q) : '0;
    bus.rsp_valid = (state_q == StResp) ? (NUM_REQ'(1) << win_q) : '0;
    bus.rsp_rdata = rdata_q;
    bus.busy      = (state_q != StIdle) || lock_q;
    bus.t_addr    = addr_q;
    bus.t_wdata   = wdata_q;
    bus.t_wr_en   = (state_q == StAccess) && wr_q;
  end
endmodule

// File: tb/tb_timer_bus_arbiter.sv
// Bench for timer_bus_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level scheduling model.
module tb_timer_bus_arbiter;
  localparam int unsigned NUM_REQ = 2;
  localparam int unsigned ADDR_W  = 6;
  localparam int unsigned DATA_W  = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  timer_bus_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  timer_bus_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Timer register file: combinational read, write on the edge ending ACCESS.
  logic [7:0] tmem [64];
  logic       tm_ready = 1'b0;
  assign bus.t_rdata = tmem[bus.t_addr];
  always @(posedge clk) begin
    if (!tm_ready) begin
      for (int i = 0; i < 64; i++) tmem[i] <= 8'(i) ^ 8'h5E;
      tm_ready <= 1'b1;
    end else if (bus.t_wr_en) begin
      tmem[bus.t_addr] <= bus.t_wdata;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic set_req(input int i, input logic en, input logic wr, input logic lock,
                         input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bus.req[i]                        = en;
    bus.req_wr[i]                     = wr;
    bus.req_lock[i]                   = lock;
    bus.req_addr[i*ADDR_W +: ADDR_W]  = a;
    bus.req_wdata[i*DATA_W +: DATA_W] = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiesce();
    step();
    bus.req      = '0;
    bus.req_lock = '0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++; if (bus.gnt !== '0) begin n_fail++; $display("FAIL reset_gnt got=%b exp=0", bus.gnt); end
    n_tests++; if (bus.rsp_valid !== '0) begin n_fail++; $display("FAIL reset_rsp got=%b exp=0", bus.rsp_valid); end
    n_tests++; if (bus.rsp_rdata !== 8'h00) begin n_fail++; $display("FAIL reset_rdata got=%h exp=00", bus.rsp_rdata); end
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    n_tests++; if (bus.t_addr !== 6'h00) begin n_fail++; $display("FAIL reset_taddr got=%h exp=00", bus.t_addr); end
    n_tests++; if (bus.t_wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_twren got=%b exp=0", bus.t_wr_en); end
    n_tests++; if (bus.t_wdata !== 8'h00) begin n_fail++; $display("FAIL reset_twdata got=%h exp=00", bus.t_wdata); end
    rst_n = 1'b1;
    step();
    @(negedge clk);
    n_tests++; if (bus.busy !== 1'b0 || bus.gnt !== '0) begin
      n_fail++; $display("FAIL idle_after_reset got busy=%b gnt=%b exp busy=0 gnt=0", bus.busy, bus.gnt);
    end
  endtask

  task automatic test_single_read();
    step(); set_req(0, 1'b1, 1'b0, 1'b0, 6'h04, 8'h00);
    @(negedge clk);
    n_tests++; if (bus.gnt !== 2'b00) begin n_fail++; $display("FAIL rd_gnt_early got=%b exp=00", bus.gnt); end
    step(); set_req(0, 1'b0, 1'b0, 1'b0, 6'h00, 8'h00);
    @(negedge clk);
    n_tests++; if (bus.gnt !== 2'b01) begin n_fail++; $display("FAIL rd_gnt got=%b exp=01", bus.gnt); end
    n_tests++; if (bus.t_addr !== 6'h04) begin n_fail++; $display("FAIL rd_taddr got=%h exp=04", bus.t_addr); end
    n_tests++; if (bus.t_wr_en !== 1'b0) begin n_fail++; $display("FAIL rd_twren got=%b exp=0", bus.t_wr_en); end
    n_tests++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL rd_busy got=%b exp=1", bus.busy); end
    step(); @(negedge clk);
    n_tests++; if (bus.rsp_valid !== 2'b01) begin n_fail++; $display("FAIL rd_rsp got=%b exp=01", bus.rsp_valid); end
    n_tests++; if (bus.rsp_rdata !== 8'h5A) begin n_fail++; $display("FAIL rd_data got=%h exp=5a", bus.rsp_rdata); end
    n_tests++; if (bus.gnt !== 2'b00) begin n_fail++; $display("FAIL rd_gnt_resp got=%b exp=00", bus.gnt); end
    step(); @(negedge clk);
    n_tests++; if (bus.rsp_valid !== 2'b00 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL rd_done got rsp=%b busy=%b exp rsp=00 busy=0", bus.rsp_valid, bus.busy);
    end
  endtask

  task automatic test_single_write();
    step(); set_req(1, 1'b1, 1'b1, 1'b0, 6'h02, 8'hC3);
    @(negedge clk);
    n_tests++; if (bus.t_wr_en !== 1'b0) begin n_fail++; $display("FAIL wr_twren_early got=%b exp=0", bus.t_wr_en); end
    step(); set_req(1, 1'b0, 1'b0, 1'b0, 6'h00, 8'h00);
    @(negedge clk);
    n_tests++; if (bus.gnt !== 2'b10) begin n_fail++; $display("FAIL wr_gnt got=%b exp=10", bus.gnt); end
    n_tests++; if (bus.t_wr_en !== 1'b1) begin n_fail++; $display("FAIL wr_twren got=%b exp=1", bus.t_wr_en); end
    n_tests++; if (bus.t_addr !== 6'h02) begin n_fail++; $display("FAIL wr_taddr got=%h exp=02", bus.t_addr); end
    n_tests++; if (bus.t_wdata !== 8'hC3) begin n_fail++; $display("FAIL wr_twdata got=%h exp=c3", bus.t_wdata); end
    step(); @(negedge clk);
    n_tests++; if (bus.t_wr_en !== 1'b0) begin n_fail++; $display("FAIL wr_twren_len got=%b exp=0", bus.t_wr_en); end
    n_tests++; if (bus.rsp_valid !== 2'b10) begin n_fail++; $display("FAIL wr_rsp got=%b exp=10", bus.rsp_valid); end
    n_tests++; if (bus.rsp_rdata !== 8'h00) begin n_fail++; $display("FAIL wr_rdata got=%h exp=00", bus.rsp_rdata); end
    n_tests++; if (tmem[2] !== 8'hC3) begin n_fail++; $display("FAIL wr_mem got=%h exp=c3", tmem[2]); end
    step(); @(negedge clk);
    n_tests++; if (bus.t_addr !== 6'h02 || bus.t_wdata !== 8'hC3) begin
      n_fail++; $display("FAIL wr_hold got addr=%h data=%h exp addr=02 data=c3", bus.t_addr, bus.t_wdata);
    end
  endtask

  task automatic test_contention();
    int gid [8];
    int gcyc [8];
    int ngr = 0;
    int multi = 0;
    for (int k = 0; k < 13; k++) begin
      step();
      if (k == 0) begin
        set_req(0, 1'b1, 1'b0, 1'b0, 6'h05, 8'h00);
        set_req(1, 1'b1, 1'b0, 1'b0, 6'h06, 8'h00);
      end
      @(negedge clk);
      if ($countones(bus.gnt) > 1 || $countones(bus.rsp_valid) > 1) multi++;
      if (bus.gnt != '0 && ngr < 8) begin
        gid[ngr]  = bus.gnt[1] ? 1 : 0;
        gcyc[ngr] = k;
        ngr++;
      end
    end
    quiesce();
    n_tests++; if (ngr != 4) begin n_fail++; $display("FAIL cont_count got=%0d exp=4", ngr); end
    n_tests++; if (multi != 0) begin n_fail++; $display("FAIL cont_onehot got=%0d exp=0", multi); end
    for (int i = 0; i < ngr && i < 4; i++) begin
      n_tests++; if (gid[i] != (i % 2)) begin
        n_fail++; $display("FAIL cont_order i=%0d got=%0d exp=%0d", i, gid[i], i % 2);
      end
      if (i > 0) begin
        n_tests++; if (gcyc[i] - gcyc[i-1] != 3) begin
          n_fail++; $display("FAIL cont_spacing i=%0d got=%0d exp=3", i, gcyc[i] - gcyc[i-1]);
        end
      end
    end
  endtask

  task automatic test_lock();
    logic [1:0] gk [10];
    logic [1:0] rk [10];
    logic       bk [10];
    logic [7:0] dk [10];
    logic [1:0] exp_g;
    for (int k = 0; k < 10; k++) begin
      step();
      if (k == 0) set_req(1, 1'b1, 1'b1, 1'b1, 6'h10, 8'h77);
      else if (k == 1) begin
        set_req(0, 1'b1, 1'b0, 1'b0, 6'h11, 8'h00);
        set_req(1, 1'b1, 1'b0, 1'b0, 6'h10, 8'h00);
      end
      else if (k == 4) set_req(1, 1'b0, 1'b0, 1'b0, 6'h00, 8'h00);
      else if (k == 7) set_req(0, 1'b0, 1'b0, 1'b0, 6'h00, 8'h00);
      @(negedge clk);
      gk[k] = bus.gnt; rk[k] = bus.rsp_valid; bk[k] = bus.busy; dk[k] = bus.rsp_rdata;
    end
    quiesce();
    for (int k = 0; k < 10; k++) begin
      exp_g = (k == 1 || k == 4) ? 2'b10 : (k == 7) ? 2'b01 : 2'b00;
      n_tests++; if (gk[k] !== exp_g) begin
        n_fail++; $display("FAIL lock_gnt k=%0d got=%b exp=%b", k, gk[k], exp_g);
      end
    end
    for (int k = 1; k <= 5; k++) begin
      n_tests++; if (bk[k] !== 1'b1) begin n_fail++; $display("FAIL lock_busy k=%0d got=%b exp=1", k, bk[k]); end
    end
    n_tests++; if (rk[5] !== 2'b10 || dk[5] !== 8'h77) begin
      n_fail++; $display("FAIL lock_rmw got rsp=%b data=%h exp rsp=10 data=77", rk[5], dk[5]);
    end
  endtask

  task automatic test_abandon();
    logic [1:0] gk [8];
    logic       bk [8];
    for (int k = 0; k < 8; k++) begin
      step();
      if (k == 0) set_req(1, 1'b1, 1'b0, 1'b1, 6'h20, 8'h00);
      else if (k == 1) begin
        set_req(1, 1'b0, 1'b0, 1'b0, 6'h00, 8'h00);
        set_req(0, 1'b1, 1'b0, 1'b0, 6'h21, 8'h00);
      end
      else if (k == 4) set_req(0, 1'b0, 1'b0, 1'b0, 6'h00, 8'h00);
      @(negedge clk);
      gk[k] = bus.gnt; bk[k] = bus.busy;
    end
    quiesce();
    n_tests++; if (gk[1] !== 2'b10) begin n_fail++; $display("FAIL abandon_gnt1 got=%b exp=10", gk[1]); end
    n_tests++; if (bk[3] !== 1'b1) begin n_fail++; $display("FAIL abandon_busy_lock got=%b exp=1", bk[3]); end
    n_tests++; if (gk[4] !== 2'b01) begin n_fail++; $display("FAIL abandon_gnt0 got=%b exp=01", gk[4]); end
    n_tests++; if (bk[6] !== 1'b0) begin n_fail++; $display("FAIL abandon_unlock got=%b exp=0", bk[6]); end
  endtask

  task automatic test_reset_mid_write();
    int rsp_seen = 0;
    logic [1:0] g1;
    step(); set_req(1, 1'b1, 1'b1, 1'b0, 6'h30, 8'hAA);
    @(negedge clk);
    step(); set_req(1, 1'b0, 1'b0, 1'b0, 6'h00, 8'h00);
    @(negedge clk);
    n_tests++; if (bus.t_wr_en !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre got=%b exp=1", bus.t_wr_en); end
    #1 rst_n = 1'b0;
    #1;
    n_tests++; if (bus.t_wr_en !== 1'b0 || bus.gnt !== 2'b00 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_async got wren=%b gnt=%b busy=%b exp 0/00/0",
                         bus.t_wr_en, bus.gnt, bus.busy);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    n_tests++; if (tmem[6'h30] !== 8'h6E) begin n_fail++; $display("FAIL rstmid_mem got=%h exp=6e", tmem[6'h30]); end
    for (int k = 0; k < 3; k++) begin
      step(); @(negedge clk);
      if (bus.rsp_valid != '0) rsp_seen++;
    end
    n_tests++; if (rsp_seen != 0) begin n_fail++; $display("FAIL rstmid_norsp got=%0d exp=0", rsp_seen); end
    step();
    set_req(0, 1'b1, 1'b0, 1'b0, 6'h07, 8'h00);
    set_req(1, 1'b1, 1'b0, 1'b0, 6'h08, 8'h00);
    step(); @(negedge clk);
    g1 = bus.gnt;
    quiesce();
    n_tests++; if (g1 !== 2'b01) begin n_fail++; $display("FAIL rstmid_first got=%b exp=01", g1); end
  endtask

  task automatic test_random();
    logic [7:0]         m_mem [64];
    int                 m_ptr, m_owner, m_sel, m_free, m_win, j;
    logic               m_wr;
    logic [ADDR_W-1:0]  m_taddr, a;
    logic [DATA_W-1:0]  m_twdata, m_rdata, d;
    logic [NUM_REQ-1:0] obs_gnt, exp_g, exp_r;
    logic               exp_we, exp_busy;
    quiesce();
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 64; i++) m_mem[i] = tmem[i];
    m_ptr = NUM_REQ - 1; m_owner = -1; m_sel = -10; m_free = 0; m_win = -1;
    m_wr = 1'b0; m_taddr = '0; m_twdata = '0; m_rdata = '0; obs_gnt = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      step();
      for (int i = 0; i < NUM_REQ; i++) begin
        if (bus.req[i] && obs_gnt[i]) begin
          if ($urandom_range(1, 0) != 0)
            set_req(i, 1'b1, 1'($urandom_range(1, 0)), ($urandom_range(3, 0) == 0),
                    6'($urandom_range(15, 0)), 8'($urandom));
          else set_req(i, 1'b0, 1'b0, 1'b0, 6'h00, 8'h00);
        end else if (bus.req[i]) begin
          if ($urandom_range(15, 0) == 0 && !(m_sel == cyc - 1 && m_win == i))
            set_req(i, 1'b0, 1'b0, 1'b0, 6'h00, 8'h00);
        end else if ($urandom_range(2, 0) == 0) begin
          set_req(i, 1'b1, 1'($urandom_range(1, 0)), ($urandom_range(3, 0) == 0),
                  6'($urandom_range(15, 0)), 8'($urandom));
        end
      end
      @(negedge clk);
      exp_g    = (cyc == m_sel + 1) ? (NUM_REQ'(1) << m_win) : '0;
      exp_r    = (cyc == m_sel + 2) ? (NUM_REQ'(1) << m_win) : '0;
      exp_we   = (cyc == m_sel + 1) && m_wr;
      exp_busy = (cyc == m_sel + 1) || (cyc == m_sel + 2) || (m_owner >= 0);
      n_tests++; if (bus.gnt !== exp_g) begin
        n_fail++; $display("FAIL rnd_gnt cyc=%0d got=%b exp=%b", cyc, bus.gnt, exp_g);
      end
      n_tests++; if (bus.rsp_valid !== exp_r) begin
        n_fail++; $display("FAIL rnd_rsp cyc=%0d got=%b exp=%b", cyc, bus.rsp_valid, exp_r);
      end
      n_tests++; if (bus.t_wr_en !== exp_we) begin
        n_fail++; $display("FAIL rnd_twren cyc=%0d got=%b exp=%b", cyc, bus.t_wr_en, exp_we);
      end
      n_tests++; if (bus.t_addr !== m_taddr || bus.t_wdata !== m_twdata) begin
        n_fail++; $display("FAIL rnd_tbus cyc=%0d got=%h/%h exp=%h/%h", cyc, bus.t_addr,
                           bus.t_wdata, m_taddr, m_twdata);
      end
      n_tests++; if (bus.busy !== exp_busy) begin
        n_fail++; $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", cyc, bus.busy, exp_busy);
      end
      if (exp_r != '0) begin
        n_tests++; if (bus.rsp_rdata !== m_rdata) begin
          n_fail++; $display("FAIL rnd_rdata cyc=%0d got=%h exp=%h", cyc, bus.rsp_rdata, m_rdata);
        end
      end
      obs_gnt = bus.gnt;
      if (cyc >= m_free) begin
        if (m_owner >= 0 && !bus.req[m_owner]) m_owner = -1;
        m_win = -1;
        for (int off = 1; off <= NUM_REQ; off++) begin
          j = (m_ptr + off) % NUM_REQ;
          if (m_win < 0 && bus.req[j] && (m_owner < 0 || m_owner == j)) m_win = j;
        end
        if (m_win >= 0) begin
          m_sel  = cyc;
          m_free = cyc + 3;
          m_ptr  = m_win;
          m_wr   = bus.req_wr[m_win];
          a      = bus.req_addr[m_win*ADDR_W +: ADDR_W];
          d      = bus.req_wdata[m_win*DATA_W +: DATA_W];
          m_taddr  = a;
          m_twdata = d;
          if (m_wr) begin
            m_mem[a] = d;
            m_rdata  = '0;
          end else begin
            m_rdata = m_mem[a];
          end
          if (bus.req_lock[m_win]) m_owner = m_win;
          else if (m_owner == m_win) m_owner = -1;
        end
      end
    end
    quiesce();
  endtask

  initial begin
    bus.req       = '0;
    bus.req_wr    = '0;
    bus.req_lock  = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    test_reset();
    test_single_read();
    test_single_write();
    test_contention();
    test_lock();
    test_abandon();
    test_reset_mid_write();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
